pc_call_stack_unit: RTL

- Parametrised program counter for the PIC16-class core. It holds the PC and PCLATH, and adds a hardware call/return stack.
- Supports the following PC updates:
  - sequential increment
  - computed jump (PCL write)
  - GOTO/CALL with a literal plus the PCLATH page bits
  - RETURN
- Sits between the instruction decoder/controller and the program memory address bus. Feeds fetch and the PCL/PCLATH register-file read paths.

---
 rtl/pic_pc_pkg.sv | 19 +
 rtl/hw_return_stack.sv | 71 +++++++
 rtl/pc_call_stack_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/pic_pc_pkg.sv
// Shared constants and the PC-source encoding for the PIC16-class program counter.
package pic_pc_pkg;

  localparam int PIC_LATH_WIDTH   = 5;
  localparam int PIC_LIT_WIDTH    = 11;
  localparam int PIC_STACK_DEPTH  = 8;
  localparam int PIC_RESET_VECTOR = 0;

  // Winning PC source for a cycle, listed from lowest to highest priority.
  typedef enum logic [2:0] {
    PC_SRC_HOLD,
    PC_SRC_INCR,
    PC_SRC_RET,
    PC_SRC_GOTO,
    PC_SRC_CALL,
    PC_SRC_PCL
  } pc_src_e;

endpackage

// File: rtl/hw_return_stack.sv
// Circular LIFO for return addresses; oldest entries are silently overwritten.
// Optional occupancy/overflow/underflow status under `PC_STACK_STATUS_EN`.
module hw_return_stack #(
  parameter int DATA_WIDTH = 13,
  parameter int DEPTH      = 8,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [PTR_W-1:0]      ptr
`ifdef PC_STACK_STATUS_EN
  ,
  output logic [PTR_W:0]        stack_level,
  output logic                  stack_ovf,
  output logic                  stack_unf
`endif
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      w_ptr_dec;

  // Power-of-two depth lets the pointer wrap by plain overflow.
  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign top_data  = r_mem[w_ptr_dec];
  assign ptr       = r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
    end else if (pop) begin
      r_ptr <= w_ptr_dec;
    end
  end

`ifdef PC_STACK_STATUS_EN
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0] r_level;
  logic           r_ovf;
  logic           r_unf;

  // Level saturates at both ends; the flags record that saturation was hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (push) begin
      if (r_level == FULL_LEVEL) r_ovf <= 1'b1;
      else                       r_level <= r_level + (PTR_W+1)'(1);
    end else if (pop) begin
      if (r_level == '0) r_unf <= 1'b1;
      else               r_level <= r_level - (PTR_W+1)'(1);
    end
  end

  assign stack_level = r_level;
  assign stack_ovf   = r_ovf;
  assign stack_unf   = r_unf;
`endif

endmodule

// File: rtl/pc_call_stack_unit.sv
// PIC16-class program counter with PCLATH and hardware return stack.
// Define PC_STACK_STATUS_EN to add stack_level/stack_ovf/stack_unf outputs.
module pc_call_stack_unit
  import pic_pc_pkg::*;
#(
  parameter int LATH_WIDTH  = PIC_LATH_WIDTH,
  parameter int LIT_WIDTH   = PIC_LIT_WIDTH,
  parameter int STACK_DEPTH = PIC_STACK_DEPTH,
  localparam int PC_WIDTH   = 8 + LATH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  incr_pc_en,
  input  logic                  pcl_wr_en,
  input  logic [7:0]            pcl_in,
  input  logic                  pclath_wr_en,
  input  logic [LATH_WIDTH-1:0] pclath_in,
  input  logic                  goto_en,
  input  logic                  call_en,
  input  logic                  ret_en,
  input  logic [LIT_WIDTH-1:0]  lit_in,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [LATH_WIDTH-1:0] pclath_out,
  output logic [7:0]            pcl_out
`ifdef PC_STACK_STATUS_EN
  ,
  output logic [$clog2(STACK_DEPTH):0] stack_level,
  output logic                         stack_ovf,
  output logic                         stack_unf
`endif
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0]   r_pc;
  logic [LATH_WIDTH-1:0] r_pclath;

  pc_src_e               w_pc_src;
  logic [PC_WIDTH-1:0]   w_pc_plus1;
  logic [PC_WIDTH-1:0]   w_target;
  logic [PC_WIDTH-1:0]   w_pcl_jump;
  logic [PC_WIDTH-1:0]   w_top_data;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic [PTR_W-1:0]      w_sp;
  logic                  w_push;
  logic                  w_pop;

  // Page bits come from the PCLATH bits above the literal; old PCLATH is used.
  assign w_target   = {r_pclath[LATH_WIDTH-1:LIT_WIDTH-8], lit_in};
  assign w_pcl_jump = {r_pclath, pcl_in};
  assign w_pc_plus1 = r_pc + PC_WIDTH'(1);

  always_comb begin
    w_pc_src = PC_SRC_HOLD;
    if (pcl_wr_en)       w_pc_src = PC_SRC_PCL;
    else if (call_en)    w_pc_src = PC_SRC_CALL;
    else if (goto_en)    w_pc_src = PC_SRC_GOTO;
    else if (ret_en)     w_pc_src = PC_SRC_RET;
    else if (incr_pc_en) w_pc_src = PC_SRC_INCR;
  end

  // Only the winning source touches the stack, so losers have no side effects.
  assign w_push = (w_pc_src == PC_SRC_CALL);
  assign w_pop  = (w_pc_src == PC_SRC_RET);

  always_comb begin
    w_pc_next = r_pc;
    case (w_pc_src)
      PC_SRC_PCL:  w_pc_next = w_pcl_jump;
      PC_SRC_CALL: w_pc_next = w_target;
      PC_SRC_GOTO: w_pc_next = w_target;
      PC_SRC_RET:  w_pc_next = w_top_data;
      PC_SRC_INCR: w_pc_next = w_pc_plus1;
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= PC_WIDTH'(PIC_RESET_VECTOR);
      r_pclath <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (pclath_wr_en) r_pclath <= pclath_in;
    end
  end

  hw_return_stack #(
    .DATA_WIDTH (PC_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push        (w_push),
    .pop         (w_pop),
    .push_data   (w_pc_plus1),
    .top_data    (w_top_data),
    .ptr         (w_sp)
`ifdef PC_STACK_STATUS_EN
    ,
    .stack_level (stack_level),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
`endif
  );

  assign pc_out     = r_pc;
  assign pclath_out = r_pclath;
  assign pcl_out    = r_pc[7:0];

endmodule
